// File: rtl/sseg_scan_mux.sv
// Scan driver for a common-anode multi-digit 7-segment display: one nibble and
// one active-low anode per slot, with frame-synchronous updates and blanking.
module sseg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    scan_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    // load is a one-cycle strobe with no ready: every edge that sees load=1
    // overwrites the pending register, so the last strobe before a frame
    // boundary is the one that gets displayed.
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_supp;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic                    an_on;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    dp_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A digit is suppressed when it and everything to its left is a zero
    // nibble with no decimal point; digit 0 always stays lit.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active[4*i +: 4] == 4'h0) && !act_dp[i];
            if (i != 0) begin
                supp[i] = lz_blank && zero_run;
            end
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib  = active[4*i +: 4];
                cur_dp   = act_dp[i];
                cur_supp = supp[i];
            end
        end
    end

    always_comb begin
        an_on   = (cnt >= CNT_BLANK) && !cur_supp;
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_on && (idx == IW'(i))) begin
                an_next[i] = 1'b0;
            end
        end
        dp_next = an_on ? ~cur_dp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            pending   <= '0;
            active    <= '0;
            pend_dp   <= '0;
            act_dp    <= '0;
            hex       <= 4'h0;
            an        <= '1;
            dp        <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            scan_tick <= slot_end;

            // Commit reads pending before this edge's load lands, so a load
            // coinciding with the wrap waits one more frame.
            if (frame_end) begin
                active <= pending;
                act_dp <= pend_dp;
            end
            if (load) begin
                pending <= value;
                pend_dp <= dp_in;
            end

            hex <= cur_nib;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with a 4-digit, 4-clock-slot, 1-clock-blank
// configuration; every slot is checked cycle by cycle against hand values.
module tb_sseg_scan_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BL = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic        scan_tick;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .lz_blank (lz_blank),
        .hex      (hex),
        .an       (an),
        .dp       (dp),
        .scan_tick(scan_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Starts at a negedge where the DUT is at cnt=0 of slot s; ends at cnt=0
    // of the next slot. ld_step k asserts load for the edge that sees cnt=k.
    task automatic run_slot(input string name, input int s, input bit on, input bit dpv,
                            input int ld_step, input logic [15:0] lv, input logic [3:0] ldp);
        logic [3:0] eh;
        logic [3:0] ean;
        logic       edp;
        eh  = exp_q.pop_front();
        ean = 4'hF;
        if (on) ean[s] = 1'b0;
        edp = on ? ~dpv : 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == ld_step) begin
                value = lv;
                dp_in = ldp;
                load  = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("%s s%0d k%0d an", name, s, k), an, (k == 0) ? 4'hF : ean);
            chk($sformatf("%s s%0d k%0d hex", name, s, k), hex, eh);
            chk($sformatf("%s s%0d k%0d dp", name, s, k), dp, (k == 0) ? 1'b1 : edp);
            chk($sformatf("%s s%0d k%0d tick", name, s, k), scan_tick, (k == 3) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] shown, input logic [3:0] on,
                             input logic [3:0] dpv, input int ld_slot, input int ld_step,
                             input logic [15:0] lv, input logic [3:0] ldp);
        for (int s = 0; s < ND; s++) exp_q.push_back(shown[4*s +: 4]);
        for (int s = 0; s < ND; s++) begin
            run_slot(name, s, on[s], dpv[s], (s == ld_slot) ? ld_step : -1, lv, ldp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        lz_blank = 1'b1;

        // Reset held for three edges: outputs parked.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst c%0d an", c), an, 4'hF);
            chk($sformatf("rst c%0d dp", c), dp, 1'b1);
            chk($sformatf("rst c%0d hex", c), hex, 4'h0);
            chk($sformatf("rst c%0d tick", c), scan_tick, 1'b0);
        end
        rst_n = 1'b1;

        // Zeros with suppression: only digit 0 lit. Queue 1A2F for next frame.
        run_frame("after_rst", 16'h0000, 4'b0001, 4'b0000, 0, 0, 16'h1A2F, 4'b0000);

        lz_blank = 1'b0;
        run_frame("basic1", 16'h1A2F, 4'b1111, 4'b0000, -1, 0, 16'h0000, 4'b0000);
        run_frame("basic2", 16'h1A2F, 4'b1111, 4'b0000, 0, 0, 16'h0050, 4'b0000);

        lz_blank = 1'b1;
        run_frame("lz", 16'h0050, 4'b0011, 4'b0000, 0, 0, 16'h0050, 4'b0100);
        // Decimal point on digit 2 stops suppression there; load lands mid-frame.
        run_frame("lz_dp", 16'h0050, 4'b0111, 4'b0100, 2, 1, 16'h1234, 4'b0000);
        run_frame("tear", 16'h1234, 4'b1111, 4'b0000, 1, 0, 16'h5678, 4'b0000);
        // BEEF loaded on the wrap edge: next frame still shows 5678.
        run_frame("pre_wrap", 16'h5678, 4'b1111, 4'b0000, 3, 3, 16'hBEEF, 4'b0000);
        run_frame("wrap_old", 16'h5678, 4'b1111, 4'b0000, -1, 0, 16'h0000, 4'b0000);

        // BEEF frame, interrupted by reset at cnt=2 of slot 2.
        exp_q.push_back(4'hF);
        exp_q.push_back(4'hE);
        run_slot("beef", 0, 1'b1, 1'b0, -1, 16'h0000, 4'b0000);
        run_slot("beef", 1, 1'b1, 1'b0, -1, 16'h0000, 4'b0000);
        @(negedge clk);
        chk("beef s2 k0 an", an, 4'hF);
        chk("beef s2 k0 hex", hex, 4'hE);
        @(negedge clk);
        chk("beef s2 k1 an", an, 4'b1011);
        chk("beef s2 k1 hex", hex, 4'hE);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst an", an, 4'hF);
        chk("midrst hex", hex, 4'h0);
        chk("midrst dp", dp, 1'b1);
        chk("midrst tick", scan_tick, 1'b0);
        rst_n = 1'b1;

        // Scan restarts at digit 0 and nothing pending survives.
        run_frame("post_rst1", 16'h0000, 4'b0001, 4'b0000, -1, 0, 16'h0000, 4'b0000);
        run_frame("post_rst2", 16'h0000, 4'b0001, 4'b0000, -1, 0, 16'h0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
